// File: rtl/fetch_ctrl.sv
// fetch_ctrl: fetch-stage sequencer.
// Owns the fetch PC, drives the instruction-bus request handshake, buffers an
// instruction while decode is stalled, and absorbs control-flow redirects.
// Ports:
//   clk, reset (async, active low)
//   ireq_valid/ireq_addr         : instruction-bus request
//   iresp_data_ok/iresp_data     : instruction-bus response
//   stall_in                     : downstream cannot accept this cycle
//   redirect_valid/redirect_pc   : jump/branch/trap target from execute
//   out_valid/out_pc/out_instr   : instruction presented to the fetch register
//   fetch_stall/fetch_jump       : bubble / squash controls for the fetch register
// Outputs are combinational: a response is passed through the same cycle it arrives.
module fetch_ctrl #(
    parameter int unsigned         XLEN     = 64,
    parameter int unsigned         INSTR_W  = 32,
    parameter logic [XLEN-1:0]     PC_RESET = XLEN'(64'h8000_0000)
) (
    input  logic               clk,
    input  logic               reset,
    output logic               ireq_valid,
    output logic [XLEN-1:0]    ireq_addr,
    input  logic               iresp_data_ok,
    input  logic [INSTR_W-1:0] iresp_data,
    input  logic               stall_in,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               out_valid,
    output logic [XLEN-1:0]    out_pc,
    output logic [INSTR_W-1:0] out_instr,
    output logic               fetch_stall,
    output logic               fetch_jump
);

    localparam logic [1:0] FETCH   = 2'd0;
    localparam logic [1:0] HOLD    = 2'd1;
    localparam logic [1:0] DISCARD = 2'd2;

    localparam logic [XLEN-1:0] PC_STEP    = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

    logic [1:0]         state, state_nx;
    logic [XLEN-1:0]    pc, pc_nx;
    logic [XLEN-1:0]    pend_pc, pend_pc_nx;
    logic [INSTR_W-1:0] buffer, buffer_nx;
    logic [XLEN-1:0]    tgt;

    // Redirect targets are always word aligned; low bits are dropped on load.
    assign tgt = redirect_pc & ALIGN_MASK;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FETCH;
            pc      <= PC_RESET;
            pend_pc <= '0;
            buffer  <= '0;
        end else begin
            state   <= state_nx;
            pc      <= pc_nx;
            pend_pc <= pend_pc_nx;
            buffer  <= buffer_nx;
        end
    end

    // Next-state and output decode; redirect always wins over delivery and stall.
    always_comb begin
        state_nx   = state;
        pc_nx      = pc;
        pend_pc_nx = pend_pc;
        buffer_nx  = buffer;
        ireq_valid = 1'b0;
        ireq_addr  = pc;
        out_valid  = 1'b0;
        out_pc     = '0;
        out_instr  = '0;

        case (state)
            FETCH: begin
                ireq_valid = 1'b1;
                if (redirect_valid) begin
                    if (iresp_data_ok) begin
                        pc_nx = tgt;
                    end else begin
                        // Request cannot be withdrawn; drop its response later.
                        pend_pc_nx = tgt;
                        state_nx   = DISCARD;
                    end
                end else if (iresp_data_ok) begin
                    out_valid = 1'b1;
                    out_pc    = pc;
                    out_instr = iresp_data;
                    if (stall_in) begin
                        buffer_nx = iresp_data;
                        state_nx  = HOLD;
                    end else begin
                        pc_nx = pc + PC_STEP;
                    end
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_nx    = tgt;
                    state_nx = FETCH;
                end else begin
                    out_valid = 1'b1;
                    out_pc    = pc;
                    out_instr = buffer;
                    if (!stall_in) begin
                        pc_nx    = pc + PC_STEP;
                        state_nx = FETCH;
                    end
                end
            end
            DISCARD: begin
                ireq_valid = 1'b1;
                if (redirect_valid) begin
                    pend_pc_nx = tgt;
                end
                if (iresp_data_ok) begin
                    pc_nx    = redirect_valid ? tgt : pend_pc;
                    state_nx = FETCH;
                end
            end
            default: begin
                state_nx = FETCH;
            end
        endcase

        // Hold the bus and fetch register quiet while reset is asserted.
        if (!reset) begin
            ireq_valid = 1'b0;
            out_valid  = 1'b0;
            out_pc     = '0;
            out_instr  = '0;
        end
    end

    assign fetch_jump  = redirect_valid;
    assign fetch_stall = !reset || (!out_valid && !redirect_valid);

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    localparam logic [63:0] PC_RST = 64'h8000_0000;

    typedef struct {
        logic [63:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        ireq_valid;
    logic [63:0] ireq_addr;
    logic        iresp_data_ok;
    logic [31:0] iresp_data;
    logic        stall_in;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        out_valid;
    logic [63:0] out_pc;
    logic [31:0] out_instr;
    logic        fetch_stall;
    logic        fetch_jump;

    int   n_cmp = 0;
    int   n_err = 0;
    exp_t sbq[$];
    exp_t e;

    fetch_ctrl dut (
        .clk            (clk),
        .reset          (reset),
        .ireq_valid     (ireq_valid),
        .ireq_addr      (ireq_addr),
        .iresp_data_ok  (iresp_data_ok),
        .iresp_data     (iresp_data),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .out_valid      (out_valid),
        .out_pc         (out_pc),
        .out_instr      (out_instr),
        .fetch_stall    (fetch_stall),
        .fetch_jump     (fetch_jump)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog");
    end

    // Apply one cycle of inputs in the low phase; outputs are settled 1ns later.
    task automatic drive(input logic dok, input logic [31:0] d, input logic stall,
                         input logic redir, input logic [63:0] rpc);
        @(negedge clk);
        iresp_data_ok  = dok;
        iresp_data     = d;
        stall_in       = stall;
        redirect_valid = redir;
        redirect_pc    = rpc;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        sbq.delete();
        #1;
        @(negedge clk);
        reset = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_cmp++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL rst_ireq_valid: got %b want 0", ireq_valid); end
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
        n_cmp++; if (out_pc !== 64'h0) begin n_err++; $display("FAIL rst_out_pc: got %h want 0", out_pc); end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL rst_fetch_stall: got %b want 1", fetch_stall); end
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (ireq_valid !== 1'b1) begin n_err++; $display("FAIL rel_ireq_valid: got %b want 1", ireq_valid); end
        n_cmp++; if (ireq_addr !== PC_RST) begin n_err++; $display("FAIL rel_ireq_addr: got %h want %h", ireq_addr, PC_RST); end
    endtask

    // Back-to-back delivery, one instruction per cycle.
    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            e.pc    = PC_RST + 64'(4 * i);
            e.instr = 32'h1000_0000 + 32'(i);
            sbq.push_back(e);
            drive(1'b1, e.instr, 1'b0, 1'b0, '0);
            n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid[%0d]: got %b want 1", i, out_valid); end
            n_cmp++; if (fetch_stall !== 1'b0) begin n_err++; $display("FAIL b2b_stall[%0d]: got %b want 0", i, fetch_stall); end
            e = sbq.pop_front();
            n_cmp++; if (out_pc !== e.pc || out_instr !== e.instr) begin
                n_err++; $display("FAIL b2b_data[%0d]: got %h/%h want %h/%h", i, out_pc, out_instr, e.pc, e.instr);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== PC_RST + 64'hC) begin n_err++; $display("FAIL b2b_next_addr: got %h want %h", ireq_addr, PC_RST + 64'hC); end
    endtask

    // Stall holds the buffered instruction and suppresses new requests.
    task automatic test_hold();
        do_reset();
        e.pc = PC_RST; e.instr = 32'hAAAA_0001;
        sbq.push_back(e);
        drive(1'b1, e.instr, 1'b1, 1'b0, '0);
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'hAAAA_0001) begin
            n_err++; $display("FAIL hold_present: got %b/%h want 1/aaaa0001", out_valid, out_instr);
        end
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'hDEAD_BEEF, 1'b1, 1'b0, '0);
            n_cmp++; if (ireq_valid !== 1'b0) begin n_err++; $display("FAIL hold_ireq[%0d]: got %b want 0", i, ireq_valid); end
            n_cmp++; if (out_valid !== 1'b1 || out_instr !== sbq[0].instr || out_pc !== sbq[0].pc) begin
                n_err++; $display("FAIL hold_held[%0d]: got %b/%h/%h want 1/%h/%h", i, out_valid, out_pc, out_instr, sbq[0].pc, sbq[0].instr);
            end
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        e = sbq.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
            n_err++; $display("FAIL hold_accept: got %b/%h/%h want 1/%h/%h", out_valid, out_pc, out_instr, e.pc, e.instr);
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST + 64'h4) begin
            n_err++; $display("FAIL hold_next_req: got %b/%h want 1/%h", ireq_valid, ireq_addr, PC_RST + 64'h4);
        end
    endtask

    // Redirect while a request is outstanding: its late response is dropped.
    task automatic test_discard();
        do_reset();
        drive(1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b1, 64'h8000_0100);
        n_cmp++; if (fetch_jump !== 1'b1 || out_valid !== 1'b0 || ireq_addr !== PC_RST + 64'h4) begin
            n_err++; $display("FAIL disc_redirect: got jump=%b valid=%b addr=%h want 1/0/%h", fetch_jump, out_valid, ireq_addr, PC_RST + 64'h4);
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST + 64'h4) begin
            n_err++; $display("FAIL disc_addr_stable: got %b/%h want 1/%h", ireq_valid, ireq_addr, PC_RST + 64'h4);
        end
        n_cmp++; if (fetch_stall !== 1'b1) begin n_err++; $display("FAIL disc_bubble: got %b want 1", fetch_stall); end
        drive(1'b1, 32'h2222_2222, 1'b0, 1'b0, '0);
        n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL disc_drop: got %b want 0", out_valid); end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== 64'h8000_0100) begin n_err++; $display("FAIL disc_target: got %h want 80000100", ireq_addr); end
    endtask

    // Redirect coincident with data_ok never delivers the stale instruction.
    task automatic test_redirect_same_cycle();
        do_reset();
        drive(1'b1, 32'h3333_3333, 1'b0, 1'b1, 64'h8000_0200);
        n_cmp++; if (out_valid !== 1'b0 || fetch_jump !== 1'b1 || fetch_stall !== 1'b0) begin
            n_err++; $display("FAIL same_cycle_ctrl: got valid=%b jump=%b stall=%b want 0/1/0", out_valid, fetch_jump, fetch_stall);
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== 64'h8000_0200) begin n_err++; $display("FAIL same_cycle_addr: got %h want 80000200", ireq_addr); end
    endtask

    // Latest redirect during DISCARD wins; low target bits are cleared.
    task automatic test_double_redirect();
        do_reset();
        drive(1'b0, '0, 1'b0, 1'b1, 64'h300);
        drive(1'b0, '0, 1'b0, 1'b1, 64'h400);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== PC_RST) begin n_err++; $display("FAIL dbl_old_addr: got %h want %h", ireq_addr, PC_RST); end
        drive(1'b1, 32'h4444_4444, 1'b0, 1'b0, '0);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== 64'h400) begin n_err++; $display("FAIL dbl_latest: got %h want 400", ireq_addr); end
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b1, 64'h403);
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== 64'h400) begin n_err++; $display("FAIL dbl_align: got %h want 400", ireq_addr); end
    endtask

    // Asynchronous reset while holding a buffered instruction.
    task automatic test_reset_in_hold();
        do_reset();
        drive(1'b1, 32'h6666_6666, 1'b1, 1'b0, '0);
        drive(1'b0, '0, 1'b1, 1'b0, '0);
        n_cmp++; if (out_valid !== 1'b1 || out_instr !== 32'h6666_6666) begin
            n_err++; $display("FAIL rih_before: got %b/%h want 1/66666666", out_valid, out_instr);
        end
        #1;
        reset = 1'b0;
        #1;
        n_cmp++; if (out_valid !== 1'b0 || out_pc !== 64'h0 || out_instr !== 32'h0 || ireq_valid !== 1'b0 || fetch_stall !== 1'b1) begin
            n_err++; $display("FAIL rih_clear: got v=%b pc=%h i=%h req=%b st=%b want 0/0/0/0/1", out_valid, out_pc, out_instr, ireq_valid, fetch_stall);
        end
        stall_in = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        #1;
        n_cmp++; if (ireq_valid !== 1'b1 || ireq_addr !== PC_RST) begin
            n_err++; $display("FAIL rih_release: got %b/%h want 1/%h", ireq_valid, ireq_addr, PC_RST);
        end
    endtask

    // PC increment wraps at the top of the address space.
    task automatic test_wrap();
        do_reset();
        drive(1'b1, '0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
        e.pc = 64'hFFFF_FFFF_FFFF_FFFC; e.instr = 32'h7777_7777;
        sbq.push_back(e);
        drive(1'b1, e.instr, 1'b0, 1'b0, '0);
        e = sbq.pop_front();
        n_cmp++; if (out_valid !== 1'b1 || out_pc !== e.pc || out_instr !== e.instr) begin
            n_err++; $display("FAIL wrap_deliver: got %b/%h/%h want 1/%h/%h", out_valid, out_pc, out_instr, e.pc, e.instr);
        end
        drive(1'b0, '0, 1'b0, 1'b0, '0);
        n_cmp++; if (ireq_addr !== 64'h0) begin n_err++; $display("FAIL wrap_next: got %h want 0", ireq_addr); end
    endtask

    initial begin
        reset          = 1'b0;
        iresp_data_ok  = 1'b0;
        iresp_data     = '0;
        stall_in       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        test_reset();
        test_back_to_back();
        test_hold();
        test_discard();
        test_redirect_same_cycle();
        test_double_redirect();
        test_reset_in_hold();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch-stage sequencer. Owns the architectural fetch PC, drives the instruction-bus request handshake, and absorbs backend stalls and redirects.
- Presents one instruction per cycle to the fetch pipeline register, together with its stall/jump (bubble) controls.
- Sits between the instruction bus and the fetch register. Fed by decode (stall) and execute (redirect).

Parameters:
- PC_RESET, 64'h8000_0000, fetch PC after reset.
- XLEN, 64, PC width.
- INSTR_W, 32, instruction width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- ireq_valid  out  1  instruction fetch request.
- ireq_addr  out  XLEN  fetch address.
- iresp_data_ok  in  1  response valid; completes the current request.
- iresp_data  in  INSTR_W  fetched instruction, valid when data_ok=1.
- stall_in  in  1  downstream cannot accept an instruction this cycle.
- redirect_valid  in  1  control-flow redirect (jump/branch/trap).
- redirect_pc  in  XLEN  redirect target.
- out_valid  out  1  out_instr/out_pc carry a real instruction.
- out_pc  out  XLEN  PC of out_instr.
- out_instr  out  INSTR_W  instruction to the fetch register.
- fetch_stall  out  1  bubble request to the fetch register (no instruction available).
- fetch_jump  out  1  squash request to the fetch register; equals redirect_valid.

Behaviour:
- States:
  - FETCH: request outstanding.
  - HOLD: instruction buffered, downstream stalled.
  - DISCARD: request outstanding whose response must be dropped.
- Reset (reset=0, asynchronous):
  - state=FETCH, pc=PC_RESET, pend_pc=0, buffer=0.
  - Registered outputs clear immediately.
  - While reset=0: ireq_valid=0, out_valid=0, out_pc=0, out_instr=0, fetch_stall=1.
- First cycle after reset rises: ireq_valid=1, ireq_addr=PC_RESET.
- Bus rule:
  - Once asserted, ireq_valid stays 1 and ireq_addr stays stable until the cycle data_ok=1.
  - A request is never withdrawn early; data_ok in the same cycle completes it.
- FETCH: ireq_valid=1, ireq_addr=pc.
  - data_ok=1, redirect=0, stall_in=0:
    - out_valid=1 that cycle (combinational pass-through), out_instr=iresp_data, out_pc=pc.
    - pc<=pc+4, stay FETCH. Back-to-back requests are allowed: next request next cycle.
  - data_ok=1, redirect=0, stall_in=1:
    - out_valid=1 (presented but not accepted).
    - buffer<=iresp_data, go HOLD; pc unchanged.
  - data_ok=1, redirect=1: response dropped (out_valid=0), pc<=redirect_pc, stay FETCH.
  - data_ok=0, redirect=1: pend_pc<=redirect_pc, go DISCARD; ireq_addr stays at old pc.
  - data_ok=0, redirect=0: out_valid=0, wait.
- HOLD: ireq_valid=0, out_valid=1, out_instr=buffer, out_pc=pc.
  - stall_in=0: accepted; pc<=pc+4, go FETCH.
  - redirect=1 (any stall_in): buffer dropped, out_valid=0, pc<=redirect_pc, go FETCH.
- DISCARD: ireq_valid=1, ireq_addr=old pc, out_valid=0.
  - redirect=1: pend_pc<=redirect_pc (latest wins).
  - data_ok=1: response dropped, pc<=(redirect ? redirect_pc : pend_pc), go FETCH.
- Priorities:
  - Redirect beats stall_in and beats data_ok delivery.
  - Simultaneous redirect+data_ok never delivers the stale instruction.
- Control outputs:
  - fetch_jump = redirect_valid.
  - fetch_stall = !out_valid && !redirect_valid.
  - out_valid forced 0 whenever redirect_valid=1.
- Arithmetic:
  - pc+4 wraps modulo 2^XLEN.
  - redirect_pc[1:0] ignored (cleared) when loaded.
- Reset mid-request:
  - Asynchronous return to FETCH at PC_RESET.
  - The bus is reset concurrently; no stale response is expected afterwards.

Test Plan:
- Reset release, data_ok=1 every cycle, stall_in=0 -> out_pc 8000_0000, 8000_0004, 8000_0008 on consecutive cycles; out_valid=1 from the first cycle.
- data_ok at 8000_0000 with stall_in=1 for 3 cycles -> HOLD; ireq_valid=0 for 3 cycles, out_instr held, then ireq_addr=8000_0004.
- Request at 8000_0004 with data_ok=0; redirect to 8000_0100; data_ok 2 cycles later -> that response dropped (out_valid=0); next ireq_addr=8000_0100.
- Redirect to 8000_0200 in the same cycle as data_ok -> out_valid=0, fetch_jump=1; next ireq_addr=8000_0200.
- Two redirects (0x300, then 0x400) during DISCARD -> next ireq_addr=0x400. Also: redirect_pc=0x403 -> ireq_addr=0x400.
- Reset asserted while in HOLD -> outputs clear immediately; after release, ireq_addr=PC_RESET. Separately: pc=FFFF_FFFF_FFFF_FFFC, accepted -> next pc=0.
